// File: rtl/multisim_pull_pkg.sv
//------------------------------------------------------------------------------
// multisim_pull_pkg : shared types and sizing helpers for the pull unpacker
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package multisim_pull_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  function automatic int calc_ratio(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction

  // Index counters never shrink below one bit, even for a 1:1 ratio.
  function automatic int idx_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/multisim_sync_fifo.sv
//------------------------------------------------------------------------------
// multisim_sync_fifo : power-of-two synchronous FIFO with first-word-fall-through head
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module multisim_sync_fifo
  import multisim_pull_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_width(DEPTH);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("multisim_sync_fifo: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

`ifndef SYNTHESIS
  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));
`endif

endmodule

`default_nettype wire

// File: rtl/multisim_pull_unpack.sv
//------------------------------------------------------------------------------
// multisim_pull_unpack : buffers wide pull-server words and serializes them LSB slice first
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module multisim_pull_unpack
  import multisim_pull_pkg::*;
#(
  parameter int IN_WIDTH   = 64,
  parameter int OUT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last
);

  localparam int RATIO = calc_ratio(IN_WIDTH, OUT_WIDTH);
  localparam int BW    = idx_width(RATIO);
  localparam int CW    = cnt_width(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_IDX = BW'(RATIO - 1);

  generate
    if (IN_WIDTH % OUT_WIDTH != 0) begin : g_bad_ratio
      $error("multisim_pull_unpack: IN_WIDTH must be a multiple of OUT_WIDTH");
    end
  endgenerate

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [IN_WIDTH-1:0] fifo_head;
  logic [CW-1:0]       fifo_count;

  // Ready depends only on registered occupancy, never on out_rdy.
  assign in_rdy    = rst_n && !fifo_full;
  assign fifo_push = in_vld && in_rdy;

  multisim_sync_fifo #(
    .WIDTH (IN_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (in_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  ser_state_e          state_q, state_d;
  logic [IN_WIDTH-1:0] word_q, word_d;
  logic [BW-1:0]       beat_idx_q, beat_idx_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                out_last_q, out_last_d;

  // word_q holds the not-yet-emitted upper slices so each beat is a plain register copy.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    beat_idx_d = beat_idx_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    fifo_pop   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_d    = SHIFT;
          beat_idx_d = '0;
          out_data_d = fifo_head[OUT_WIDTH-1:0];
          word_d     = fifo_head >> OUT_WIDTH;
          out_last_d = (LAST_IDX == '0);
        end
      end
      SHIFT: begin
        if (out_rdy) begin
          if (!out_last_q) begin
            beat_idx_d = beat_idx_q + BW'(1);
            out_data_d = word_q[OUT_WIDTH-1:0];
            word_d     = word_q >> OUT_WIDTH;
            out_last_d = ((beat_idx_q + BW'(1)) == LAST_IDX);
          end else if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            beat_idx_d = '0;
            out_data_d = fifo_head[OUT_WIDTH-1:0];
            word_d     = fifo_head >> OUT_WIDTH;
            out_last_d = (LAST_IDX == '0);
          end else begin
            state_d    = IDLE;
            out_last_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      word_q     <= '0;
      beat_idx_q <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      beat_idx_q <= beat_idx_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
    end
  end

  assign out_vld  = (state_q == SHIFT);
  assign out_data = out_data_q;
  assign out_last = out_last_q;

`ifndef SYNTHESIS
  a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
                                  fifo_count <= CW'(FIFO_DEPTH));
`endif

endmodule

`default_nettype wire

// File: tb/tb_multisim_pull_unpack.sv
//------------------------------------------------------------------------------
// tb_multisim_pull_unpack : self-checking bench for the pull-server unpacker
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_multisim_pull_unpack;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_vld, in_rdy, out_vld, out_rdy, out_last;
  logic [63:0] in_data;
  logic [15:0] out_data;

  logic        r1_in_vld, r1_in_rdy, r1_out_vld, r1_out_rdy, r1_out_last;
  logic [63:0] r1_in_data, r1_out_data;

  int n_vec, n_err;

  // Scoreboard: words accepted but not yet fully emitted.
  logic [63:0] exp_q[$];
  int          beat_k, words_out;
  logic [15:0] prev_data;
  logic        prev_last;
  bit          prev_stall;

  multisim_pull_unpack #(.IN_WIDTH(64), .OUT_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_last(out_last)
  );

  multisim_pull_unpack #(.IN_WIDTH(64), .OUT_WIDTH(64), .FIFO_DEPTH(4)) dut_r1 (
    .clk(clk), .rst_n(rst_n), .in_vld(r1_in_vld), .in_rdy(r1_in_rdy), .in_data(r1_in_data),
    .out_vld(r1_out_vld), .out_rdy(r1_out_rdy), .out_data(r1_out_data), .out_last(r1_out_last)
  );

  function automatic logic [15:0] slice16(input logic [63:0] w, input int k);
    logic [63:0] t;
    t = w >> (16 * k);
    return t[15:0];
  endfunction

  task automatic sb_sample();
    if (!rst_n) begin
      exp_q.delete();
      beat_k     = 0;
      prev_stall = 0;
      return;
    end
    if (prev_stall) begin
      n_vec++;
      if (out_vld !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
        n_err++;
        $display("FAIL hold_stable: vld=%b data=%h last=%b, required vld=1 data=%h last=%b",
                 out_vld, out_data, out_last, prev_data, prev_last);
      end
    end
    if (in_vld && in_rdy) exp_q.push_back(in_data);
    if (out_vld === 1'b1 && out_rdy) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL spurious_beat: data=%h, required no beat", out_data);
      end else begin
        if (out_data !== slice16(exp_q[0], beat_k) || out_last !== (beat_k == 3)) begin
          n_err++;
          $display("FAIL sb_beat%0d: data=%h last=%b, required data=%h last=%b",
                   beat_k, out_data, out_last, slice16(exp_q[0], beat_k), (beat_k == 3));
        end
        if (beat_k == 3) begin
          void'(exp_q.pop_front());
          beat_k = 0;
          words_out++;
        end else begin
          beat_k++;
        end
      end
    end
    prev_stall = (out_vld === 1'b1) && !out_rdy;
    prev_data  = out_data;
    prev_last  = out_last;
  endtask

  task automatic sample();
    @(negedge clk);
    sb_sample();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int bound);
    for (int c = 0; c < bound && exp_q.size() != 0; c++) begin
      sample();
      adv();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    adv();
    adv();
    sample();
    n_vec += 4;
    if (out_vld !== 1'b0)   begin n_err++; $display("FAIL reset_vld: got %b, required 0", out_vld); end
    if (out_data !== 16'h0) begin n_err++; $display("FAIL reset_data: got %h, required 0000", out_data); end
    if (out_last !== 1'b0)  begin n_err++; $display("FAIL reset_last: got %b, required 0", out_last); end
    if (in_rdy !== 1'b0)    begin n_err++; $display("FAIL reset_in_rdy: got %b, required 0", in_rdy); end
    rst_n = 1'b1;
    adv();
    sample();
    n_vec += 2;
    if (in_rdy !== 1'b1)     begin n_err++; $display("FAIL post_reset_in_rdy: got %b, required 1", in_rdy); end
    if (r1_out_vld !== 1'b0) begin n_err++; $display("FAIL post_reset_r1_vld: got %b, required 0", r1_out_vld); end
    adv();
  endtask

  task automatic test_basic_split();
    logic [63:0] w;
    logic        ev;
    w       = 64'h4444_3333_2222_1111;
    out_rdy = 1'b1;
    in_vld  = 1'b1;
    in_data = w;
    sample();
    adv();
    in_vld = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      sample();
      ev = (c >= 2 && c <= 5);
      n_vec++;
      if (out_vld !== ev || out_last !== (c == 5) ||
          (ev && out_data !== slice16(w, c - 2))) begin
        n_err++;
        $display("FAIL basic_c%0d: vld=%b data=%h last=%b, required vld=%b data=%h last=%b",
                 c, out_vld, out_data, out_last, ev, slice16(w, c - 2), (c == 5));
      end
      adv();
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a, b, w;
    logic        ev;
    int          k;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    out_rdy = 1'b1;
    in_vld  = 1'b1;
    in_data = a;
    sample(); adv();
    in_data = b;
    sample(); adv();
    in_vld = 1'b0;
    for (int c = 2; c <= 10; c++) begin
      sample();
      ev = (c <= 9);
      k  = c - 2;
      w  = (k < 4) ? a : b;
      n_vec++;
      if (out_vld !== ev ||
          (ev && (out_data !== slice16(w, k % 4) || out_last !== (k == 3 || k == 7)))) begin
        n_err++;
        $display("FAIL b2b_c%0d: vld=%b data=%h last=%b, required vld=%b data=%h last=%b",
                 c, out_vld, out_data, out_last, ev, slice16(w, k % 4), (k == 3 || k == 7));
      end
      adv();
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] w[6];
    int idx, start, c;
    for (int i = 0; i < 6; i++) w[i] = {$urandom, $urandom};
    start   = words_out;
    idx     = 0;
    out_rdy = 1'b0;
    in_vld  = 1'b1;
    for (c = 0; c < 10; c++) begin
      in_data = w[idx];
      sample();
      n_vec++;
      if (in_rdy !== (c < 5)) begin
        n_err++;
        $display("FAIL bp_in_rdy_c%0d: got %b, required %b", c, in_rdy, (c < 5));
      end
      if (c >= 2) begin
        n_vec++;
        if (out_vld !== 1'b1 || out_data !== slice16(w[0], 0)) begin
          n_err++;
          $display("FAIL bp_head_c%0d: vld=%b data=%h, required vld=1 data=%h",
                   c, out_vld, out_data, slice16(w[0], 0));
        end
      end
      if (in_rdy) idx++;
      adv();
    end
    // Four beats drain the register; the full FIFO pops on the last one and reopens after.
    out_rdy = 1'b1;
    for (c = 10; c < 30 && idx < 6; c++) begin
      in_data = w[idx];
      sample();
      n_vec++;
      if (in_rdy !== (c >= 14)) begin
        n_err++;
        $display("FAIL bp_reopen_c%0d: in_rdy=%b, required %b", c, in_rdy, (c >= 14));
      end
      if (in_rdy) idx++;
      adv();
    end
    in_vld = 1'b0;
    drain(100);
    n_vec += 2;
    if (idx != 6) begin n_err++; $display("FAIL bp_accepted: got %0d, required 6", idx); end
    if (words_out - start != 6 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL bp_delivered: got %0d pending %0d, required 6 pending 0",
               words_out - start, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_word();
    logic [63:0] w[3];
    logic [63:0] nw;
    int nb;
    for (int i = 0; i < 3; i++) w[i] = {$urandom, $urandom};
    out_rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_vld  = 1'b1;
      in_data = w[c];
      sample();
      adv();
    end
    in_vld = 1'b0;
    sample();
    n_vec++;
    if (out_vld !== 1'b1 || out_data !== slice16(w[0], 1)) begin
      n_err++;
      $display("FAIL rmw_beat1: vld=%b data=%h, required vld=1 data=%h", out_vld, out_data, slice16(w[0], 1));
    end
    adv();
    rst_n = 1'b0;
    sample();
    n_vec++;
    if (in_rdy !== 1'b0) begin n_err++; $display("FAIL rmw_in_rdy: got %b, required 0", in_rdy); end
    adv();
    sample();
    n_vec++;
    if (out_vld !== 1'b0 || out_data !== 16'h0 || out_last !== 1'b0) begin
      n_err++;
      $display("FAIL rmw_cleared: vld=%b data=%h last=%b, required 0 0000 0", out_vld, out_data, out_last);
    end
    adv();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      sample();
      n_vec++;
      if (out_vld !== 1'b0) begin n_err++; $display("FAIL rmw_stale_c%0d: vld=%b, required 0", c, out_vld); end
      adv();
    end
    nw      = {$urandom, $urandom};
    in_vld  = 1'b1;
    in_data = nw;
    sample();
    adv();
    in_vld = 1'b0;
    nb     = 0;
    for (int c = 0; c < 12; c++) begin
      sample();
      if (out_vld === 1'b1) begin
        n_vec++;
        if (out_data !== slice16(nw, nb) || out_last !== (nb == 3)) begin
          n_err++;
          $display("FAIL rmw_new_b%0d: data=%h last=%b, required data=%h last=%b",
                   nb, out_data, out_last, slice16(nw, nb), (nb == 3));
        end
        nb++;
      end
      adv();
    end
    n_vec++;
    if (nb != 4) begin n_err++; $display("FAIL rmw_new_count: got %0d beats, required 4", nb); end
  endtask

  task automatic test_ratio1();
    int sent, got;
    sent = 0;
    got  = 0;
    for (int c = 0; c < 300 && got < 8; c++) begin
      r1_in_vld  = (sent < 8);
      r1_in_data = 64'(sent);
      r1_out_rdy = 1'($urandom_range(0, 1));
      sample();
      if (r1_out_vld === 1'b1) begin
        n_vec++;
        if (r1_out_last !== 1'b1) begin n_err++; $display("FAIL r1_last: got %b, required 1", r1_out_last); end
        if (r1_out_rdy) begin
          n_vec++;
          if (r1_out_data !== 64'(got)) begin
            n_err++;
            $display("FAIL r1_data: got %h, required %h", r1_out_data, 64'(got));
          end
          got++;
        end
      end
      if (r1_in_vld && r1_in_rdy) sent++;
      adv();
    end
    r1_in_vld  = 1'b0;
    r1_out_rdy = 1'b0;
    n_vec++;
    if (got != 8) begin n_err++; $display("FAIL r1_count: got %0d words, required 8", got); end
  endtask

  task automatic test_random_soak();
    int sent, start, c;
    sent  = 0;
    start = words_out;
    c     = 0;
    while ((sent < 10000 || exp_q.size() != 0) && c < 80000) begin
      in_vld  = (sent < 10000) && ($urandom_range(0, 9) != 0);
      in_data = {$urandom, $urandom};
      out_rdy = ($urandom_range(0, 4) != 0);
      sample();
      if (in_vld && in_rdy) sent++;
      adv();
      c++;
    end
    in_vld = 1'b0;
    n_vec++;
    if (words_out - start != 10000 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL soak_words: got %0d pending %0d after %0d cycles, required 10000 pending 0",
               words_out - start, exp_q.size(), c);
    end
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    beat_k     = 0;
    words_out  = 0;
    prev_stall = 0;
    prev_data  = '0;
    prev_last  = 1'b0;
    rst_n      = 1'b0;
    in_vld     = 1'b0;
    in_data    = '0;
    out_rdy    = 1'b0;
    r1_in_vld  = 1'b0;
    r1_in_data = '0;
    r1_out_rdy = 1'b0;
    test_reset();
    test_basic_split();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_ratio1();
    test_random_soak();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multisim_pull_unpack.md
# multisim_pull_unpack

Downstream stage of the multisim pull server. It accepts wide words from the server's valid/ready stream and buffers them in a small FIFO, which absorbs the server's DPI polling gaps. Each word is then serialized into narrower beats for the DUT, least-significant slice first, with a last-beat marker. It is synthesizable RTL and runs in both simulation and emulation builds.

## Interface
- IN_WIDTH, 64: width of words from the pull server.
- OUT_WIDTH, 16: beat width to the DUT. IN_WIDTH must be an exact multiple of OUT_WIDTH; a mismatch is an elaboration error.
- FIFO_DEPTH, 4: input FIFO entries. Must be a power of two and ≥ 2.
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  reset: synchronous, active-low.
- in_vld  input  1  word valid; connected to the server's data_vld.
- in_rdy  output  1  word ready; connected to the server's data_rdy.
- in_data  input  IN_WIDTH  word from the server.
- out_vld  output  1  beat valid.
- out_rdy  input  1  beat ready from the DUT.
- out_data  output  OUT_WIDTH  beat payload.
- out_last  output  1  high on the final beat of a word.

## Operation
- RATIO = IN_WIDTH / OUT_WIDTH. Beat k carries in_data[k*OUT_WIDTH +: OUT_WIDTH], for k = 0 … RATIO-1.
- Input handshake: a word is accepted when in_vld && in_rdy.
  - in_rdy = rst_n && (fifo_count < FIFO_DEPTH).
  - in_rdy has no combinational path from out_rdy.
- FIFO: occupancy counter width is clog2(FIFO_DEPTH)+1. Read and write pointers wrap modulo FIFO_DEPTH.
  - A simultaneous push and pop leaves the count unchanged.
  - Pushing while full and popping while empty cannot happen by construction; an assertion flags either.
- Serializer FSM:
  - IDLE: out_vld = 0. When the FIFO is non-empty, pop the head into the word register, set beat_idx = 0, go to SHIFT.
  - SHIFT: out_vld = 1, out_data = slice[beat_idx], out_last = (beat_idx == RATIO-1). On out_rdy:
    - not last: beat_idx += 1.
    - last, FIFO non-empty: pop the next word in the same cycle, beat_idx = 0, stay in SHIFT. There is no bubble.
    - last, FIFO empty: go to IDLE.
- out_data and out_last are held stable while out_vld && !out_rdy.
- RATIO = 1 degenerates to a plain FIFO with out_last tied high whenever out_vld = 1.

## Timing
- Reset (rst_n low at a rising edge):
  - FIFO empties; FSM goes to IDLE; beat_idx = 0.
  - out_vld = 0, out_data = 0, out_last = 0.
  - in_rdy = 0 while rst_n is low.
- Reset mid-word: remaining beats and FIFO contents are discarded. No partial beat is emitted after reset.
- Latency: a word accepted in cycle N produces beat 0 with out_vld high in cycle N+2.
  - Cycle N: FIFO write.
  - Cycle N+1: head visible; load into the word register.
- Throughput: one beat per cycle sustained, so one word per RATIO cycles. in_rdy drops only when the FIFO is full.
- Full FIFO with a simultaneous last-beat pop: in_rdy stays 0 in that cycle and rises the next cycle, because in_rdy is computed from the registered count.
- All outputs except in_rdy come directly from flops.

## Structure
- Package multisim_pull_pkg holds:
  - the serializer state enum (IDLE, SHIFT);
  - the function computing RATIO and the counter widths.
- Sub-module multisim_sync_fifo (parameters WIDTH, DEPTH; synchronous active-low reset; outputs full, empty, count). It is reusable by other multisim stages.
- Top level: the FIFO instance, the word register, beat_idx (width clog2(RATIO), minimum 1) and the FSM.

## Test plan
- Basic split (IN_WIDTH=64, OUT_WIDTH=16, out_rdy=1):
  - stimulus: push 0x4444_3333_2222_1111 at cycle 0;
  - response: beats 0x1111, 0x2222, 0x3333, 0x4444 in cycles 2–5, out_last only in cycle 5.
- Back-to-back (out_rdy=1):
  - stimulus: push words A and B on consecutive cycles;
  - response: 8 contiguous beats with no bubble between A's last and B's first.
- Backpressure:
  - stimulus: out_rdy=0 for 10 cycles while pushing 6 words;
  - response: in_rdy falls after the FIFO holds 4 entries plus the word in the register; out_data stays stable; no word is lost or duplicated.
- Reset mid-word:
  - stimulus: assert rst_n=0 after beat 1 of a word, with 2 words queued;
  - response: next cycle out_vld=0; after release, no stale beats; a new word emerges correctly.
- RATIO=1 (OUT_WIDTH=64):
  - stimulus: stream 0x0, 0x1, 0x2 …;
  - response: identical words in order, out_last=1 on every beat.
- Random stall soak:
  - stimulus: random in_vld/out_rdy, 10k words;
  - response: the scoreboard matches the concatenated beats to the input words.
